// File: rtl/if_fetch_if.sv
// Instruction SRAM-like fetch bus: request/address out, accept/data back.
//  inst_req      fetch request (master -> slave)
//  inst_addr     fetch address, stable while inst_req=1
//  inst_addr_ok  request accepted this cycle (slave -> master)
//  inst_data_ok  read data valid this cycle
//  inst_rdata    read data
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// IF stage: owns the PC, fetches over the SRAM-like bus and feeds IF/ID.
//  clk, rst (async, active-low)
//  stall[0] holds PC, stall[1] holds the IF/ID output; flush/new_pc redirect
//  branch_flag_i/branch_target_address_i: ID-resolved taken branch
//  inst_bus: fetch bus master
//  pc_o/inst_o/inst_valid_o/if_excepttype_o: IF/ID payload
//  stallreq_from_if: fetch outstanding
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] ADEL_CODE = 32'h00000004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_address_i,
  if_fetch_if.master        inst_bus,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic [31:0]       if_excepttype_o,
  output logic              stallreq_from_if
);
  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic          r_pend, w_pend_nxt;
  logic [AW-1:0] r_tgt, w_tgt_nxt;
  logic          w_ld_inst, w_ld_exc;
  logic          r_inst_req, r_stallreq;
  logic [AW-1:0] r_pc_o, r_inst_o, r_exc;
  logic          r_valid;
  logic          w_unused;

  assign w_unused = &{1'b0, stall[5:2]};

  // State, PC and pending-branch registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_pend  <= 1'b0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Next state, next PC and delivery strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_tgt_nxt   = r_tgt;
    w_ld_inst   = 1'b0;
    w_ld_exc    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_pc_nxt   = new_pc;
          w_pend_nxt = 1'b0;
        end else if (branch_flag_i) begin
          w_pc_nxt   = branch_target_address_i;
          w_pend_nxt = 1'b0;
        end else if (!stall[0]) begin
          if (r_pc[1:0] != 2'b00) begin
            // Misaligned: report AdEL without touching the bus
            w_ld_exc = 1'b1;
            w_pc_nxt = r_pc + AW'(4);
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          w_pc_nxt    = new_pc;
          w_pend_nxt  = 1'b0;
          // An accepted request still owes a response that must be drained
          w_state_nxt = inst_bus.inst_addr_ok ? S_DISCARD : S_IDLE;
        end else begin
          if (inst_bus.inst_addr_ok) w_state_nxt = S_WAIT;
          if (branch_flag_i) begin
            w_pend_nxt = 1'b1;
            w_tgt_nxt  = branch_target_address_i;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_pc_nxt    = new_pc;
          w_pend_nxt  = 1'b0;
          // Data arriving with the flush is simply dropped
          w_state_nxt = inst_bus.inst_data_ok ? S_IDLE : S_DISCARD;
        end else if (inst_bus.inst_data_ok) begin
          w_ld_inst   = 1'b1;
          w_pc_nxt    = branch_flag_i ? branch_target_address_i :
                        r_pend        ? r_tgt : r_pc + AW'(4);
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (branch_flag_i) begin
          w_pend_nxt = 1'b1;
          w_tgt_nxt  = branch_target_address_i;
        end
      end
      S_DISCARD: begin
        if (flush) begin
          w_pc_nxt   = new_pc;
          w_pend_nxt = 1'b0;
        end else if (branch_flag_i) begin
          w_pc_nxt   = branch_target_address_i;
          w_pend_nxt = 1'b0;
        end
        if (inst_bus.inst_data_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus request and stall request track the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_req <= 1'b0;
      r_stallreq <= 1'b0;
    end else begin
      r_inst_req <= (w_state_nxt == S_REQ);
      r_stallreq <= (w_state_nxt != S_IDLE);
    end
  end

  // IF/ID output register with stall hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_inst_o <= '0;
      r_pc_o   <= '0;
      r_exc    <= '0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_inst_o <= '0;
      r_exc    <= '0;
    end else if (w_ld_inst) begin
      r_valid  <= 1'b1;
      r_inst_o <= inst_bus.inst_rdata;
      r_pc_o   <= r_pc;
      r_exc    <= '0;
    end else if (w_ld_exc) begin
      r_valid  <= 1'b1;
      r_inst_o <= '0;
      r_pc_o   <= r_pc;
      r_exc    <= ADEL_CODE;
    end else if (!stall[1]) begin
      r_valid  <= 1'b0;
      r_inst_o <= '0;
      r_exc    <= '0;
    end
  end

  assign inst_bus.inst_req  = r_inst_req;
  assign inst_bus.inst_addr = r_pc;
  assign pc_o               = r_pc_o;
  assign inst_o             = r_inst_o;
  assign inst_valid_o       = r_valid;
  assign if_excepttype_o    = r_exc;
  assign stallreq_from_if   = r_stallreq;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, fetch, flush, delay-slot branch,
// misaligned fetch, output hold and mid-fetch reset.
module tb_if_fetch;
  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc_o, inst_o, if_excepttype_o;
  logic        inst_valid_o, stallreq_from_if;

  int n_checks;
  int n_fail;

  if_fetch_if bus ();

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_bus                (bus),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .inst_valid_o            (inst_valid_o),
    .if_excepttype_o         (if_excepttype_o),
    .stallreq_from_if        (stallreq_from_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive #1 after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst_req",   32'(bus.inst_req), 32'd0);
    check("rst_addr",  bus.inst_addr, 32'hBFC00000);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst",  inst_o, 32'd0);
    check("rst_pco",   pc_o, 32'd0);
    check("rst_exc",   if_excepttype_o, 32'd0);
    check("rst_stall", 32'(stallreq_from_if), 32'd0);

    // 1: basic fetch
    rst = 1'b1;
    tick();
    check("t1_req",   32'(bus.inst_req), 32'd1);
    check("t1_addr",  bus.inst_addr, 32'hBFC00000);
    check("t1_sreq",  32'(stallreq_from_if), 32'd1);
    bus.inst_addr_ok = 1'b1;
    tick();
    check("t1_wait_req", 32'(bus.inst_req), 32'd0);
    check("t1_wait_sreq", 32'(stallreq_from_if), 32'd1);
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h24080001;
    tick();
    check("t1_valid", 32'(inst_valid_o), 32'd1);
    check("t1_inst",  inst_o, 32'h24080001);
    check("t1_pco",   pc_o, 32'hBFC00000);
    check("t1_sreq0", 32'(stallreq_from_if), 32'd0);
    bus.inst_data_ok = 1'b0;
    tick();
    check("t1_valid_drop", 32'(inst_valid_o), 32'd0);
    check("t1_next_req",   32'(bus.inst_req), 32'd1);
    check("t1_next_addr",  bus.inst_addr, 32'hBFC00004);

    // 2: flush during WAIT drains the response
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hBFC00380;
    tick();
    check("t2_disc_sreq", 32'(stallreq_from_if), 32'd1);
    check("t2_disc_req",  32'(bus.inst_req), 32'd0);
    flush = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEADBEEF;
    tick();
    check("t2_drop_valid", 32'(inst_valid_o), 32'd0);
    check("t2_idle_sreq",  32'(stallreq_from_if), 32'd0);
    bus.inst_data_ok = 1'b0;
    tick();
    check("t2_req",  32'(bus.inst_req), 32'd1);
    check("t2_addr", bus.inst_addr, 32'hBFC00380);

    // Flush in REQ without acceptance: request withdrawn
    flush = 1'b1; new_pc = 32'hBFC00004;
    tick();
    check("req_flush_req",  32'(bus.inst_req), 32'd0);
    check("req_flush_sreq", 32'(stallreq_from_if), 32'd0);
    flush = 1'b0;
    tick();
    check("req_flush_addr", bus.inst_addr, 32'hBFC00004);

    // 3: branch while fetching the delay slot
    branch_flag_i = 1'b1; branch_target_address_i = 32'hBFC00100; bus.inst_addr_ok = 1'b1;
    tick();
    branch_flag_i = 1'b0; bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3C010000;
    tick();
    check("t3_ds_valid", 32'(inst_valid_o), 32'd1);
    check("t3_ds_inst",  inst_o, 32'h3C010000);
    check("t3_ds_pco",   pc_o, 32'hBFC00004);
    bus.inst_data_ok = 1'b0;
    tick();
    check("t3_tgt_req",  32'(bus.inst_req), 32'd1);
    check("t3_tgt_addr", bus.inst_addr, 32'hBFC00100);

    // 4: redirect to a misaligned address
    flush = 1'b1; new_pc = 32'hBFC00382;
    tick();
    flush = 1'b0;
    tick();
    check("t4_req",   32'(bus.inst_req), 32'd0);
    check("t4_valid", 32'(inst_valid_o), 32'd1);
    check("t4_exc",   if_excepttype_o, 32'h00000004);
    check("t4_inst",  inst_o, 32'd0);
    check("t4_pco",   pc_o, 32'hBFC00382);
    flush = 1'b1; new_pc = 32'hBFC00400;
    tick();
    check("t4_flush_valid", 32'(inst_valid_o), 32'd0);
    check("t4_flush_exc",   if_excepttype_o, 32'd0);
    flush = 1'b0;
    tick();
    check("t4_req2_addr", bus.inst_addr, 32'hBFC00400);

    // 5: IF/ID output held under stall[1]
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hAABBCCDD;
    stall = 6'b000011;
    tick();
    bus.inst_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", 32'(inst_valid_o), 32'd1);
      check("t5_hold_inst",  inst_o, 32'hAABBCCDD);
      check("t5_hold_pco",   pc_o, 32'hBFC00400);
      check("t5_hold_req",   32'(bus.inst_req), 32'd0);
      tick();
    end
    check("t5_last_valid", 32'(inst_valid_o), 32'd1);
    stall = '0;
    tick();
    check("t5_rel_valid", 32'(inst_valid_o), 32'd0);
    check("t5_rel_req",   32'(bus.inst_req), 32'd1);
    check("t5_rel_addr",  bus.inst_addr, 32'hBFC00404);

    // 6: reset during WAIT, late data ignored
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_sreq",  32'(stallreq_from_if), 32'd0);
    check("t6_req",   32'(bus.inst_req), 32'd0);
    check("t6_valid", 32'(inst_valid_o), 32'd0);
    check("t6_pco",   pc_o, 32'd0);
    check("t6_addr",  bus.inst_addr, 32'hBFC00000);
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hFFFFFFFF;
    tick();
    rst = 1'b1;
    tick();
    check("t6_late_valid", 32'(inst_valid_o), 32'd0);
    check("t6_late_inst",  inst_o, 32'd0);
    check("t6_refetch_req",  32'(bus.inst_req), 32'd1);
    check("t6_refetch_addr", bus.inst_addr, 32'hBFC00000);
    bus.inst_data_ok = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
